// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parametrised up/down counter family.
//   DIR_UP / DIR_DN : encoding of the up_dn direction input.
//   clamp_load      : limits a parallel-load value to the top of the count
//                     range (min(val, modulus-1)).
// ---------------------------------------------------------------------------
package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // 64-bit arguments so that MODULUS == 2**32 (WIDTH = 32) is representable.
   function automatic logic [63:0] clamp_load(input logic [63:0] val,
                                              input logic [63:0] modulus);
      return (val > (modulus - 64'd1)) ? (modulus - 64'd1) : val;
   endfunction

endpackage : counter_pkg

// File: rtl/up_down_counter_param.sv
// ---------------------------------------------------------------------------
// up_down_counter_param
// Configurable-width modulo-MODULUS up/down counter with synchronous clear,
// parallel load (clamped to MODULUS-1), count enable, and either wrap or
// saturate behaviour at the range ends.
//
// Parameters
//   WIDTH    : counter width in bits (1..32)
//   MODULUS  : count range is 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   Clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous clear to 0 (highest priority)
//   load     in   synchronous parallel load of load_val
//   load_val in   value to load, clamped to MODULUS-1
//   en       in   count enable (lowest priority)
//   up_dn    in   1 = count up, 0 = count down
//   count    out  registered count value
//   tc       out  combinational terminal count (next enabled step hits an end)
//   wrap     out  registered one-cycle pulse after a wrap (SATURATE=0 only)
//   sat      out  registered level while held at an end (SATURATE=1 only)
// ---------------------------------------------------------------------------
module up_down_counter_param
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 16,
   parameter bit     SATURATE = 1'b0
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             at_top;
   logic             at_bottom;
   logic             at_end;
   logic [WIDTH-1:0] load_clamped;

   // All end-of-range compares are done at WIDTH bits, so MODULUS == 2**WIDTH
   // wraps naturally without needing a carry bit.
   always_comb begin
      at_top       = (count == MAX_CNT);
      at_bottom    = (count == '0);
      at_end       = (up_dn == DIR_UP) ? at_top : at_bottom;
      load_clamped = WIDTH'(clamp_load(64'(load_val), 64'(MODULUS)));
   end

   assign tc = en & at_end;

   // NOTE: state registers use non-blocking assignments so every register in
   // this block samples the pre-edge values of count/at_end, regardless of
   // statement order.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (en) begin
         if (!at_end) begin
            // Ordinary step; also a step away from a held end, so sat drops.
            count <= (up_dn == DIR_UP) ? count + ONE : count - ONE;
            wrap  <= 1'b0;
            sat   <= 1'b0;
         end else if (SATURATE) begin
            wrap  <= 1'b0;
            sat   <= 1'b1;
         end else begin
            count <= (up_dn == DIR_UP) ? '0 : MAX_CNT;
            wrap  <= 1'b1;
            sat   <= 1'b0;
         end
      end else begin
         // Idle: count and sat hold, wrap is only ever a single-cycle pulse.
         wrap <= 1'b0;
      end
   end

endmodule : up_down_counter_param

// File: tb/tb_up_down_counter_param.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_param
// Three instances share one stimulus stream:
//   dut_a : WIDTH=4, MODULUS=10, wrap
//   dut_b : WIDTH=4, MODULUS=10, saturate
//   dut_c : WIDTH=4, MODULUS=16, wrap (full binary range)
// Directed table and hand sequences first, then random stimulus against a
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_up_down_counter_param;

   logic       Clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;

   logic [3:0] cnt_a, cnt_b, cnt_c;
   logic       tc_a, tc_b, tc_c;
   logic       wrap_a, wrap_b, wrap_c;
   logic       sat_a, sat_b, sat_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
      .Clk(Clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));

   up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
      .Clk(Clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b));

   up_down_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_c (
      .Clk(Clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .sat(sat_c));

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One rising edge, then settle a little so registered outputs are stable.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [63:0] dut_count(input int i);
      case (i)
         0:       return 64'(cnt_a);
         1:       return 64'(cnt_b);
         default: return 64'(cnt_c);
      endcase
   endfunction

   function automatic logic dut_tc(input int i);
      case (i)
         0:       return tc_a;
         1:       return tc_b;
         default: return tc_c;
      endcase
   endfunction

   function automatic logic dut_wrap(input int i);
      case (i)
         0:       return wrap_a;
         1:       return wrap_b;
         default: return wrap_c;
      endcase
   endfunction

   function automatic logic dut_sat(input int i);
      case (i)
         0:       return sat_a;
         1:       return sat_b;
         default: return sat_c;
      endcase
   endfunction

   // ------------------------------------------------------ reference model
   int mod_of [3] = '{10, 10, 16};
   bit sat_of [3] = '{1'b0, 1'b1, 1'b0};
   int m_count [3];
   bit m_wrap  [3];
   bit m_sat   [3];

   function automatic bit model_tc(input int i);
      return en && ((up_dn && m_count[i] == mod_of[i] - 1) ||
                    (!up_dn && m_count[i] == 0));
   endfunction

   // Apply one clock edge to the model using the current inputs.
   task automatic model_edge(input int i);
      int m;
      m = mod_of[i];
      if (clr) begin
         m_count[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end else if (load) begin
         m_count[i] = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
         m_wrap[i] = 0; m_sat[i] = 0;
      end else if (en) begin
         int target;
         target = up_dn ? m_count[i] + 1 : m_count[i] - 1;
         if (target >= 0 && target < m) begin
            m_count[i] = target; m_wrap[i] = 0; m_sat[i] = 0;
         end else if (sat_of[i]) begin
            m_wrap[i] = 0; m_sat[i] = 1;
         end else begin
            m_count[i] = (target + m) % m; m_wrap[i] = 1; m_sat[i] = 0;
         end
      end else begin
         m_wrap[i] = 0;
      end
   endtask

   // --------------------------------------------------------- vector table
   typedef struct {
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic       en;
      logic       up;
      int         exp_count;
      logic       exp_wrap;
      logic       exp_tc;
   } vec_t;

   function automatic vec_t mk(input logic c, input logic l, input logic [3:0] lv,
                               input logic e, input logic u, input int cnt,
                               input logic w, input logic t);
      vec_t v;
      v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
      v.exp_count = cnt; v.exp_wrap = w; v.exp_tc = t;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];

      // ---------------------------------------------------------- reset
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("por count[%0d]", i), dut_count(i), 0);
         check($sformatf("por wrap[%0d]", i), 64'(dut_wrap(i)), 0);
         check($sformatf("por sat[%0d]", i), 64'(dut_sat(i)), 0);
      end
      step();
      step();
      en = 1'b1; up_dn = 1'b1;
      rst = 1'b0;
      repeat (7) step();
      check("pre-reset count", 64'(cnt_a), 7);
      // Mid-cycle reset must clear immediately, without a clock edge.
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("async rst count[%0d]", i), dut_count(i), 0);
         check($sformatf("async rst wrap[%0d]", i), 64'(dut_wrap(i)), 0);
         check($sformatf("async rst sat[%0d]", i), 64'(dut_sat(i)), 0);
      end
      step();
      step();
      check("held rst count", 64'(cnt_a), 0);
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("post-rst count %0d", k), 64'(cnt_a), 64'(k));
      end

      // ------------------------------------------------ table (dut_a, mod 10)
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(0, 0, 0, 1, 1, (k + 1) % 10, k == 9, k == 9));
      vecs.push_back(mk(0, 0, 0,  1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 2,  0, 1, 2, 0, 0));
      vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,  1, 0, 9, 1, 1));
      vecs.push_back(mk(0, 0, 0,  1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 13, 0, 1, 9, 0, 0));
      vecs.push_back(mk(1, 1, 4,  1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 4,  1, 1, 4, 0, 0));
      vecs.push_back(mk(0, 0, 0,  0, 1, 4, 0, 0));

      foreach (vecs[i]) begin
         clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].lv;
         en = vecs[i].en; up_dn = vecs[i].up;
         #1;
         check($sformatf("vec%0d tc", i), 64'(tc_a), 64'(vecs[i].exp_tc));
         step();
         check($sformatf("vec%0d count", i), 64'(cnt_a), 64'(vecs[i].exp_count));
         check($sformatf("vec%0d wrap", i), 64'(wrap_a), 64'(vecs[i].exp_wrap));
         check($sformatf("vec%0d sat", i), 64'(sat_a), 0);
      end

      // ------------------------------------------- saturate (dut_b, mod 10)
      clr = 1'b0; load = 1'b1; load_val = 4'd8; en = 1'b0; up_dn = 1'b1;
      step();
      load = 1'b0; en = 1'b1;
      #1 check("sat tc at 8", 64'(tc_b), 0);
      step();
      check("sat count 9a", 64'(cnt_b), 9);
      check("sat flag 9a", 64'(sat_b), 0);
      #1 check("sat tc at 9", 64'(tc_b), 1);
      step();
      check("sat count 9b", 64'(cnt_b), 9);
      check("sat flag 9b", 64'(sat_b), 1);
      step();
      check("sat count 9c", 64'(cnt_b), 9);
      check("sat flag 9c", 64'(sat_b), 1);
      check("sat wrap tied", 64'(wrap_b), 0);
      up_dn = 1'b0;
      #1 check("sat tc dn at 9", 64'(tc_b), 0);
      step();
      check("sat reverse count", 64'(cnt_b), 8);
      check("sat reverse flag", 64'(sat_b), 0);

      // ------------------------------------- full binary range (dut_c, 16)
      load = 1'b1; load_val = 4'd14; en = 1'b0; up_dn = 1'b1;
      step();
      load = 1'b0; en = 1'b1;
      step();
      check("bin count 15", 64'(cnt_c), 15);
      #1 check("bin tc en=1", 64'(tc_c), 1);
      en = 1'b0;
      #1 check("bin tc en=0", 64'(tc_c), 0);
      step();
      check("bin hold 15", 64'(cnt_c), 15);
      check("bin hold wrap", 64'(wrap_c), 0);
      en = 1'b1;
      step();
      check("bin wrap count", 64'(cnt_c), 0);
      check("bin wrap pulse", 64'(wrap_c), 1);
      up_dn = 1'b0;
      #1 check("bin tc down at 0", 64'(tc_c), 1);
      step();
      check("bin down wrap count", 64'(cnt_c), 15);
      check("bin down wrap pulse", 64'(wrap_c), 1);
      step();
      check("bin down step", 64'(cnt_c), 14);
      check("bin wrap drops", 64'(wrap_c), 0);

      // ------------------------------------------------------- random
      clr = 1'b1; load = 1'b0; en = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         m_count[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end
      for (int n = 0; n < 500; n++) begin
         clr      = ($urandom_range(31) == 0);
         load     = ($urandom_range(15) == 0);
         load_val = 4'($urandom_range(15));
         en       = ($urandom_range(3) != 0);
         up_dn    = ($urandom_range(5) >= 2);
         #1;
         for (int i = 0; i < 3; i++)
            check($sformatf("rnd%0d tc[%0d]", n, i), 64'(dut_tc(i)), 64'(model_tc(i)));
         step();
         for (int i = 0; i < 3; i++) begin
            model_edge(i);
            check($sformatf("rnd%0d count[%0d]", n, i), dut_count(i), 64'(m_count[i]));
            check($sformatf("rnd%0d wrap[%0d]", n, i), 64'(dut_wrap(i)), 64'(m_wrap[i]));
            check($sformatf("rnd%0d sat[%0d]", n, i), 64'(dut_sat(i)), 64'(m_sat[i]));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_up_down_counter_param
